// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: ROB entry type shared by the reorder buffer, RS and dispatch
package reorder_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrapping W-bit pointer (clk, reset async clear, clear sync clear, inc step, ptr value)
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (clear) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer (alloc_* dispatch, cdb_* writeback, q1/q2 lookups, rd/RegWrite/WriteData/commit_valid commit, empty)
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_wr,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_data,
  output logic [31:0]      q2_data,
  output logic [4:0]       rd,
  output logic             RegWrite,
  output logic [31:0]      WriteData,
  output logic             commit_valid,
  output logic             empty
);
  rob_entry_t       rob [DEPTH];
  rob_entry_t       hd;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             alloc_fire, q1_hit, q2_hit;
  rob_ptr #(.W(TAG_W)) u_head (.clk(clk), .reset(reset), .clear(flush), .inc(commit_valid), .ptr(head));
  rob_ptr #(.W(TAG_W)) u_tail (.clk(clk), .reset(reset), .clear(flush), .inc(alloc_fire), .ptr(tail));
  always_comb begin
    hd           = rob[head];
    alloc_ready  = count != (TAG_W+1)'(DEPTH);
    alloc_tag    = tail;
    alloc_fire   = alloc_valid & alloc_ready & !flush;
    empty        = count == '0;
    commit_valid = hd.valid & hd.done & !flush;
    RegWrite     = commit_valid & hd.wr & (hd.rd != 5'd0);
    rd           = commit_valid ? hd.rd : 5'd0;
    WriteData    = commit_valid ? hd.data : 32'd0;
    q1_hit       = cdb_valid & (cdb_tag == q1_tag);
    q2_hit       = cdb_valid & (cdb_tag == q2_tag);
    q1_ready     = rob[q1_tag].valid & (rob[q1_tag].done | q1_hit);
    q2_ready     = rob[q2_tag].valid & (rob[q2_tag].done | q2_hit);
    q1_data      = q1_hit ? cdb_data : rob[q1_tag].data;
    q2_data      = q2_hit ? cdb_data : rob[q2_tag].data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
    end else if (flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
      if (alloc_fire) begin
        rob[tail].valid <= 1'b1;
        rob[tail].done  <= 1'b0;
        rob[tail].wr    <= alloc_wr;
        rob[tail].rd    <= alloc_rd;
      end
      if (cdb_valid && rob[cdb_tag].valid) begin
        rob[cdb_tag].data <= cdb_data;
        rob[cdb_tag].done <= 1'b1;
      end
      if (commit_valid) rob[head].valid <= 1'b0;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;
  logic        clk = 0, reset = 1, flush = 0;
  logic        alloc_valid = 0, alloc_wr = 0;
  logic [4:0]  alloc_rd = 0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 0;
  logic [3:0]  cdb_tag = 0, q1_tag = 0, q2_tag = 0;
  logic [31:0] cdb_data = 0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic [4:0]  rd;
  logic        RegWrite, commit_valid, empty;
  logic [31:0] WriteData;
  int          passed = 0, total = 0, m_tail = 0;
  int          tag_q[$];
  logic [4:0]  e_rd [16];
  logic        e_wr [16];
  logic [31:0] e_data [16];

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_wr(alloc_wr),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .rd(rd), .RegWrite(RegWrite), .WriteData(WriteData),
    .commit_valid(commit_valid), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    tag_q.delete();
    m_tail = 0;
  endtask

  task automatic alloc(input logic [4:0] r, input logic w);
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_tag", alloc_tag, m_tail);
    alloc_valid = 1; alloc_rd = r; alloc_wr = w;
    e_rd[m_tail] = r; e_wr[m_tail] = w;
    tag_q.push_back(m_tail);
    m_tail = (m_tail + 1) % 16;
    tick();
    alloc_valid = 0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
    e_data[t] = d;
    tick();
    cdb_valid = 0;
  endtask

  always @(negedge clk)
    if (!reset && commit_valid) begin
      if (tag_q.size() == 0) chk("unexpected_commit", commit_valid, 0);
      else begin
        int t;
        t = tag_q.pop_front();
        chk("sb_rd", rd, e_rd[t]);
        chk("sb_regwrite", RegWrite, e_wr[t] && e_rd[t] != 0);
        chk("sb_wdata", WriteData, e_data[t]);
      end
    end

  initial begin
    int n;
    #2;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_empty", empty, 1);
    chk("rst_commit", commit_valid, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_q1_ready", q1_ready, 0);
    tick();
    reset = 0;
    alloc(1, 1); alloc(2, 1); alloc(3, 1);
    chk("t1_not_empty", empty, 0);
    reset = 1;
    model_clear();
    #2;
    chk("t1_empty", empty, 1);
    chk("t1_alloc_tag", alloc_tag, 0);
    chk("t1_regwrite", RegWrite, 0);
    tick();
    reset = 0;
    tick();
    chk("t1_no_stale", commit_valid, 0);

    alloc(5, 1);
    cdb(0, 32'hDEADBEEF);
    chk("t2_regwrite", RegWrite, 1);
    chk("t2_rd", rd, 5);
    chk("t2_wdata", WriteData, 32'hDEADBEEF);
    tick();
    chk("t2_empty", empty, 1);

    alloc(1, 1); alloc(2, 1);
    cdb(2, 32'h22222222);
    chk("t3_wait_head", commit_valid, 0);
    q2_tag = 2;
    #1;
    chk("t3_q2_ready", q2_ready, 1);
    chk("t3_q2_data", q2_data, 32'h22222222);
    cdb(1, 32'h11111111);
    chk("t3_first", WriteData, 32'h11111111);
    tick();
    chk("t3_second", WriteData, 32'h22222222);
    tick();
    chk("t3_empty", empty, 1);

    reset = 1; model_clear(); tick(); reset = 0;
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 1);
    chk("t4_full", alloc_ready, 0);
    cdb(0, 32'h0000A5A5);
    chk("t4_commit", commit_valid, 1);
    alloc_valid = 1; alloc_rd = 5'd30; alloc_wr = 1;
    tick();
    alloc_valid = 0;
    chk("t4_refused_ready", alloc_ready, 1);
    chk("t4_wrap_tag", alloc_tag, 0);
    alloc(5'd20, 1);
    chk("t4_full_again", alloc_ready, 0);
    for (int i = 1; i <= 16; i++) cdb(4'(i % 16), 32'h100 + i);
    n = 0;
    while (!empty && n < 40) begin tick(); n++; end
    chk("t4_drained", empty, 1);

    n = m_tail;
    alloc(0, 1); alloc(7, 0);
    cdb(4'(n), 32'h55);
    chk("t5_commit_a", commit_valid, 1);
    chk("t5_regwrite_a", RegWrite, 0);
    cdb(4'((n + 1) % 16), 32'h77);
    chk("t5_commit_b", commit_valid, 1);
    chk("t5_regwrite_b", RegWrite, 0);
    tick();
    chk("t5_empty", empty, 1);

    reset = 1; model_clear(); tick(); reset = 0;
    alloc(1, 1); alloc(2, 1); alloc(3, 1);
    q1_tag = 2; q2_tag = 1;
    cdb_valid = 1; cdb_tag = 2; cdb_data = 32'h1234; flush = 1;
    #1;
    chk("t6_q1_ready", q1_ready, 1);
    chk("t6_q1_data", q1_data, 32'h1234);
    chk("t6_q2_ready", q2_ready, 0);
    chk("t6_flush_commit", commit_valid, 0);
    tick();
    flush = 0; cdb_valid = 0;
    model_clear();
    chk("t6_empty", empty, 1);
    chk("t6_q1_cleared", q1_ready, 0);
    tick();
    chk("t6_no_commit", commit_valid, 0);
    chk("sb_drained", tag_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
